// File: rtl/fpu_issue_ctrl_if.sv
// Signal bundle between the CPU request/response ports, the fpu core
// and fpu_issue_ctrl; slave is the controller view, master the environment.
interface fpu_issue_ctrl_if #(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter int FUNCT_W = 5
);
    logic               req_valid;
    logic               req_ready;
    logic [FUNCT_W-1:0] req_funct;
    logic [DATA_W-1:0]  req_rs1;
    logic [DATA_W-1:0]  req_rs2;
    logic [DATA_W-1:0]  req_rs3;
    logic [DATA_W-1:0]  req_rs1_i;
    logic [TAG_W-1:0]   req_tag;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [DATA_W-1:0]  rsp_res;
    logic [TAG_W-1:0]   rsp_tag;
    logic               rsp_err;

    logic               fpu_start;
    logic [FUNCT_W-1:0] fpu_funct;
    logic [DATA_W-1:0]  fpu_rs1;
    logic [DATA_W-1:0]  fpu_rs2;
    logic [DATA_W-1:0]  fpu_rs3;
    logic [DATA_W-1:0]  fpu_rs1_i;
    logic [DATA_W-1:0]  fpu_res;
    logic               fpu_done;

    modport slave (
        input  req_valid, req_funct, req_rs1, req_rs2,
        input  req_rs3, req_rs1_i, req_tag,
        output req_ready,
        output rsp_valid, rsp_res, rsp_tag, rsp_err,
        input  rsp_ready,
        output fpu_start, fpu_funct, fpu_rs1, fpu_rs2,
        output fpu_rs3, fpu_rs1_i,
        input  fpu_res, fpu_done
    );

    modport master (
        output req_valid, req_funct, req_rs1, req_rs2,
        output req_rs3, req_rs1_i, req_tag,
        input  req_ready,
        input  rsp_valid, rsp_res, rsp_tag, rsp_err,
        output rsp_ready,
        input  fpu_start, fpu_funct, fpu_rs1, fpu_rs2,
        input  fpu_rs3, fpu_rs1_i,
        output fpu_res, fpu_done
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// FP request front-end: FIFO-buffers CPU requests, issues them one at a
// time to the fpu, and returns result/tag (or a watchdog error) in order.
module fpu_issue_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter int FUNCT_W = 5,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    fpu_issue_ctrl_if.slave bus,
    output logic            busy
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST =
        WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef struct packed {
        logic [FUNCT_W-1:0] funct;
        logic [DATA_W-1:0]  rs1;
        logic [DATA_W-1:0]  rs2;
        logic [DATA_W-1:0]  rs3;
        logic [DATA_W-1:0]  rs1_i;
        logic [TAG_W-1:0]   tag;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    entry_t            r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_cnt;

    state_t            r_state;
    entry_t            r_op;
    logic [WD_W-1:0]   r_wd;
    logic              r_start;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_res;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_expire;
    logic w_wd_sat;

    assign w_full   = (r_cnt == CNT_W'(DEPTH));
    assign w_empty  = (r_cnt == '0);
    assign w_push   = bus.req_valid && !w_full;
    assign w_pop    = (r_state == S_IDLE) && !w_empty;
    assign w_expire = (TIMEOUT != 0) && (r_wd == WD_LAST);
    assign w_wd_sat = &r_wd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= '{
                    funct: bus.req_funct,
                    rs1:   bus.req_rs1,
                    rs2:   bus.req_rs2,
                    rs3:   bus.req_rs3,
                    rs1_i: bus.req_rs1_i,
                    tag:   bus.req_tag
                };
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // fpu_done is only honoured in WAIT, so a late done is harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_wd        <= '0;
            r_start     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_res   <= '0;
        end else begin
            r_start <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_op    <= r_mem[r_rd_ptr];
                        r_start <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wd    <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.fpu_done) begin
                        r_rsp_res   <= bus.fpu_res;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        if (!w_wd_sat) begin
                            r_wd <= r_wd + WD_W'(1);
                        end
                        if (w_expire) begin
                            r_rsp_res   <= '0;
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = !w_full;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_res   = r_rsp_res;
    assign bus.rsp_tag   = r_op.tag;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.fpu_start = r_start;
    assign bus.fpu_funct = r_op.funct;
    assign bus.fpu_rs1   = r_op.rs1;
    assign bus.fpu_rs2   = r_op.rs2;
    assign bus.fpu_rs3   = r_op.rs3;
    assign bus.fpu_rs1_i = r_op.rs1_i;

    assign busy = !w_empty || (r_state != S_IDLE);
endmodule
